// File: rtl/ws2812b_tx.sv
// WS2812B serializer: pulls GRB pixels over valid/ready, emits NRZ bit cells and a latch gap.
// Gated by a synchronized PLL lock that must be stable before any frame is accepted.
module ws2812b_tx #(
  parameter int unsigned NUM_LEDS     = 64,
  parameter int unsigned BIT_CYCLES   = 26,
  parameter int unsigned T0H_CYCLES   = 7,
  parameter int unsigned T1H_CYCLES   = 15,
  parameter int unsigned LATCH_CYCLES = 1260,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned STALL_MAX    = 63
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pll_locked,
  input  logic        frame_start,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [(NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1)-1:0] led_index,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun,
  output logic        dout
);
  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int KW = $clog2(LOCK_STABLE + 1);
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int LW = $clog2(LATCH_CYCLES);

  localparam logic [2:0] S_LOCK  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  logic          lock_s1_q, lock_s2_q;
  logic [2:0]    state_q, state_d;
  logic [KW-1:0] lock_cnt_q, lock_cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [CW-1:0] cell_q, cell_d;
  logic [4:0]    bit_q, bit_d;
  logic [LW-1:0] latch_q, latch_d;
  logic [23:0]   shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          unr_q, unr_d;
  logic [CW-1:0] th;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_s1_q  <= 1'b0;
      lock_s2_q  <= 1'b0;
      state_q    <= S_LOCK;
      lock_cnt_q <= '0;
      stall_q    <= '0;
      cell_q     <= '0;
      bit_q      <= '0;
      latch_q    <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      unr_q      <= 1'b0;
    end else begin
      lock_s1_q  <= pll_locked;
      lock_s2_q  <= lock_s1_q;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      stall_q    <= stall_d;
      cell_q     <= cell_d;
      bit_q      <= bit_d;
      latch_q    <= latch_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      unr_q      <= unr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    stall_d    = stall_q;
    cell_d     = cell_q;
    bit_d      = bit_q;
    latch_d    = latch_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    unr_d      = unr_q;
    case (state_q)
      S_LOCK: begin
        if (!lock_s2_q) lock_cnt_d = '0;
        else if (lock_cnt_q == KW'(LOCK_STABLE - 1)) begin
          lock_cnt_d = '0;
          state_d    = S_IDLE;
        end else lock_cnt_d = lock_cnt_q + 1'b1;
      end
      S_IDLE: begin
        if (frame_start) begin
          idx_d   = '0;
          unr_d   = 1'b0;
          stall_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pixel_valid) begin
          shift_d = pixel_data;
          cell_d  = '0;
          bit_d   = '0;
          stall_d = '0;
          state_d = S_SEND;
        end else if (stall_q == SW'(STALL_MAX - 1)) begin
          unr_d   = 1'b1;
          latch_d = '0;
          state_d = S_LATCH;
        end else stall_d = stall_q + 1'b1;
      end
      S_SEND: begin
        if (cell_q == CW'(BIT_CYCLES - 1)) begin
          cell_d  = '0;
          shift_d = {shift_q[22:0], 1'b0};
          if (bit_q == 5'd23) begin
            if (idx_q == IW'(NUM_LEDS - 1)) begin
              latch_d = '0;
              state_d = S_LATCH;
            end else begin
              idx_d   = idx_q + 1'b1;
              stall_d = '0;
              state_d = S_LOAD;
            end
          end else bit_d = bit_q + 1'b1;
        end else cell_d = cell_q + 1'b1;
      end
      S_LATCH: begin
        if (latch_q == LW'(LATCH_CYCLES - 1)) begin
          latch_d = '0;
          state_d = S_IDLE;
        end else latch_d = latch_q + 1'b1;
      end
      default: state_d = S_LOCK;
    endcase
    // Lock loss overrides everything and abandons any frame in flight.
    if (!lock_s2_q && state_q != S_LOCK) begin
      state_d    = S_LOCK;
      lock_cnt_d = '0;
    end
  end

  assign th          = shift_q[23] ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);
  assign dout        = (state_q == S_SEND) && (cell_q < th);
  assign pixel_ready = (state_q == S_LOAD);
  assign busy        = (state_q == S_LOAD) || (state_q == S_SEND) || (state_q == S_LATCH);
  assign frame_done  = (state_q == S_LATCH) && (latch_q == LW'(LATCH_CYCLES - 1)) && lock_s2_q;
  assign underrun    = unr_q;
  assign led_index   = idx_q;
endmodule
